// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the two-channel TDM multiplexer: default data
// width, channel encoding and output-stage state encoding.
package tdm_mux_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic {
    CH0 = 1'b0,
    CH1 = 1'b1
  } ch_e;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_mux_if.sv
// Bus bundle for tdm_mux: two valid/ready input channels and one
// valid/ready output carrying data plus the source-channel select.
interface tdm_mux_if #(
  parameter int WIDTH = tdm_mux_pkg::WIDTH_DEF
);

  logic [WIDTH-1:0] Data_in_0;
  logic             valid_0;
  logic             ready_0;
  logic [WIDTH-1:0] Data_in_1;
  logic             valid_1;
  logic             ready_1;
  logic [WIDTH-1:0] Data_out;
  logic             sel;
  logic             valid_out;
  logic             ready_out;

  // Mux side
  modport slave (
    input  Data_in_0, valid_0, Data_in_1, valid_1, ready_out,
    output ready_0, ready_1, Data_out, sel, valid_out
  );

  // Source/sink side
  modport master (
    output Data_in_0, valid_0, Data_in_1, valid_1, ready_out,
    input  ready_0, ready_1, Data_out, sel, valid_out
  );

endinterface

// File: rtl/tdm_mux_rr_arbiter2.sv
// Two-requester round-robin arbiter. Grant is combinational from the
// current requests; the last-grant pointer moves only when the caller
// actually consumes a grant (advance=1 with a non-zero grant).
module rr_arbiter2
  import tdm_mux_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  ch_e last_q, last_d;

  // Grant selection: a lone requester wins, contention goes to the
  // channel that did not win last time.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == CH0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Pointer next-state: update only on a consumed grant.
  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00))
      last_d = grant[1] ? CH1 : CH0;
  end

  // Pointer register; reset to CH1 so channel 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (rst) last_q <= CH1;
    else     last_q <= last_d;
  end

endmodule

// File: rtl/tdm_mux.sv
// Two-channel time-division multiplexer. A round-robin arbiter picks the
// input channel; a one-entry output register (EMPTY/FULL FSM) holds the
// merged word and its source select for the downstream demux.
module tdm_mux
  import tdm_mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
)(
  input logic       clk,
  input logic       rst,
  tdm_mux_if.slave  bus
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             sel_q, sel_d;
  logic             load_en;
  logic             any_grant;
  logic [1:0]       grant;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({bus.valid_1, bus.valid_0}),
    .advance (load_en),
    .grant   (grant)
  );

  // Output-stage FSM and register next-state. The register may load when
  // empty or when its word is leaving this cycle; rst blocks any load so
  // no input transfer happens in a reset cycle.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    sel_d     = sel_q;
    load_en   = !rst && ((state_q == EMPTY) || bus.ready_out);
    any_grant = load_en && (grant != 2'b00);
    if (any_grant) begin
      state_d = FULL;
      if (grant[1]) begin
        data_d = bus.Data_in_1;
        sel_d  = CH1;
      end else begin
        data_d = bus.Data_in_0;
        sel_d  = CH0;
      end
    end else if (load_en) begin
      // Word drained (or nothing held) and nothing new: data/sel retained.
      state_d = EMPTY;
    end
  end

  // State and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
    end
  end

  assign bus.ready_0   = load_en && grant[0];
  assign bus.ready_1   = load_en && grant[1];
  assign bus.Data_out  = data_q;
  assign bus.sel       = sel_q;
  assign bus.valid_out = (state_q == FULL);

endmodule

// File: doc/tdm_mux.md
TDM_MUX -- requirements
Module: tdm_mux

Interface
REQ-001 Parameter WIDTH, default 8: data width of every data port, in bits.
REQ-002 clk  input  1  the single clock; all state changes on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high, sampled on the rising edge of clk.
REQ-004 Data_in_0  input  WIDTH  channel 0 data.
REQ-005 valid_0  input  1  channel 0 word present.
REQ-006 ready_0  output  1  channel 0 word accepted this cycle.
REQ-007 Data_in_1  input  WIDTH  channel 1 data.
REQ-008 valid_1  input  1  channel 1 word present.
REQ-009 ready_1  output  1  channel 1 word accepted this cycle.
REQ-010 Data_out  output  WIDTH  merged data, registered.
REQ-011 sel  output  1  source channel of Data_out (0 or 1), registered; drives the select of the downstream 1-to-2 demux.
REQ-012 valid_out  output  1  Data_out/sel hold a word.
REQ-013 ready_out  input  1  downstream accepts the word this cycle.

Function
REQ-014 A transfer on any port SHALL occur on a rising edge where both valid and ready of that port are high.
REQ-015 The output stage SHALL be a 2-state FSM: EMPTY (valid_out=0) and FULL (valid_out=1).
REQ-016 load_en SHALL be 1 in EMPTY, and 1 in FULL only when ready_out=1; otherwise 0.
REQ-017 EMPTY->FULL on any input grant; FULL->EMPTY on an output transfer with no grant; FULL->FULL on an output transfer with a grant, or while ready_out=0.
REQ-018 Grant: only one valid channel -> that channel; both valid -> the channel not granted last (round-robin); neither valid -> none.
REQ-019 ready_0 and ready_1 SHALL equal load_en AND the respective grant; they are combinational and never both 1.
REQ-020 On a grant, Data_out SHALL take the granted Data_in_x and sel SHALL take x on the same edge; latency input-to-output is 1 cycle.
REQ-021 The last-grant pointer SHALL update only on an actual grant.
REQ-022 Throughput SHALL be one word per cycle when ready_out=1 continuously.
REQ-023 While valid_out=1 and ready_out=0, Data_out and sel SHALL hold stable, and ready_0 = ready_1 = 0.
REQ-024 ready_out changing while EMPTY SHALL have no effect; in EMPTY, Data_out and sel retain their last values.
REQ-025 A valid_x deasserted before its grant SHALL NOT be tracked or remembered.

Reset
REQ-026 While rst=1: state EMPTY, valid_out=0, Data_out=0, sel=0, ready_0=ready_1=0, last-grant pointer=1 (channel 0 wins the first contention).
REQ-027 rst asserted while FULL SHALL discard the held word; no input transfer occurs in a reset cycle.
REQ-028 rst has priority over all other inputs on the same edge.

Structure
REQ-029 A shared package SHALL hold the WIDTH default, the channel encoding (CH0=0, CH1=1) and the FSM state encoding (EMPTY, FULL).
REQ-030 The round-robin logic SHALL be a separate sub-module, rr_arbiter2: inputs clk, rst, req[1:0], advance; output grant[1:0]; internal last-grant pointer.
REQ-031 The output register and FSM SHALL reside in tdm_mux.

Verification
REQ-032 Reset: rst=1 for 2 cycles with valid_0=valid_1=1 -> valid_out=0, ready_0=ready_1=0, sel=0, Data_out=0.
REQ-033 Contention: valid_0=valid_1=1 constant, Data_in_0=8'hA0, Data_in_1=8'hB1, ready_out=1 -> outputs alternate A0/sel0, B1/sel1, A0/sel0, ... one word per cycle, first A0 one cycle after reset release.
REQ-034 Backpressure: FULL with 8'h5C, ready_out=0 for 3 cycles -> Data_out=8'h5C and sel held, ready_0=ready_1=0; after ready_out=1, the next word appears on the following edge.
REQ-035 Single channel: only valid_1=1 with Data_in_1=8'h11, 8'h22 -> both words emitted with sel=1, back-to-back, with no channel 0 slots.
REQ-036 Reset mid-operation: FULL with 8'h7E, ready_out=0, assert rst -> next edge valid_out=0; word never transferred.
REQ-037 Round-trip: tdm_mux feeding the 1-to-2 demux via Data_out/sel -> each demux output matches its source channel sequence exactly.
